// File: rtl/if_stage_fetch.sv
// ----------------------------------------------------------------------------
// if_stage_fetch
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program
// counter, presents it to a combinational instruction memory, and captures the
// returned word together with PC+4 into the IF/ID pipeline register.
//
// Ports:
//   clk            in   pipeline clock, rising-edge active
//   rst_n          in   asynchronous, active-low reset
//   stall          in   hazard unit: hold PC and IF/ID
//   flush          in   force IF/ID to a bubble
//   branch_taken   in   branch resolved taken (older than any jump)
//   branch_target  in   byte address of the taken branch
//   jump           in   jump decoded in ID
//   jump_target    in   byte address of the jump
//   imem_addr      out  current PC, straight from the PC register
//   imem_data      in   instruction word for imem_addr, same cycle
//   ifid_inst      out  registered instruction to ID
//   ifid_pc_plus4  out  registered PC+4 of that instruction
//   ifid_valid     out  IF/ID holds a real instruction
//   addr_err       out  sticky flag: a misaligned redirect target was seen
//   fetch_count    out  saturating count of instructions delivered to IF/ID
// ----------------------------------------------------------------------------
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0064,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        ifid_inst,
    output logic [31:0]        ifid_pc_plus4,
    output logic               ifid_valid,
    output logic               addr_err,
    output logic [COUNT_W-1:0] fetch_count
);

    // sll $0,$0,0 -- a stage that ignores ifid_valid still executes a nop
    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;

    logic [31:0]        pc_q,            pc_d;
    logic [31:0]        ifid_inst_q,     ifid_inst_d;
    logic [31:0]        ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic               ifid_valid_q,    ifid_valid_d;
    logic               addr_err_q,      addr_err_d;
    logic [COUNT_W-1:0] fetch_count_q,   fetch_count_d;

    logic        redir;
    logic [31:0] tgt;
    logic        tgt_misaligned;
    logic [31:0] pc_plus4;
    logic        count_full;

    // Redirect decode: the branch is the older instruction, so its target
    // wins when a branch and a jump resolve in the same cycle.
    always_comb begin
        redir          = branch_taken | jump;
        tgt            = branch_taken ? branch_target : jump_target;
        tgt_misaligned = (tgt[1:0] != 2'b00);
        pc_plus4       = pc_q + 32'd4;
        count_full     = (fetch_count_q == {COUNT_W{1'b1}});
    end

    // Next-state selection, highest priority first. A bubble clears the
    // instruction and valid bit but leaves pc_plus4 untouched. Redirect is
    // checked before stall because the wrong-path fetch must be discarded
    // even when the hazard unit is holding the front end.
    always_comb begin
        pc_d            = pc_q;
        ifid_inst_d     = ifid_inst_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_valid_d    = ifid_valid_q;
        addr_err_d      = addr_err_q;
        fetch_count_d   = fetch_count_q;

        if (addr_err_q) begin
            // frozen until reset
            ifid_inst_d  = BUBBLE_INST;
            ifid_valid_d = 1'b0;
        end else if (redir && tgt_misaligned) begin
            addr_err_d   = 1'b1;
            ifid_inst_d  = BUBBLE_INST;
            ifid_valid_d = 1'b0;
        end else if (redir) begin
            pc_d         = tgt;
            ifid_inst_d  = BUBBLE_INST;
            ifid_valid_d = 1'b0;
        end else if (stall) begin
            // everything holds, flush included
            pc_d = pc_q;
        end else if (flush) begin
            pc_d         = pc_plus4;
            ifid_inst_d  = BUBBLE_INST;
            ifid_valid_d = 1'b0;
        end else begin
            pc_d            = pc_plus4;
            ifid_inst_d     = imem_data;
            ifid_pc_plus4_d = pc_plus4;
            ifid_valid_d    = 1'b1;
            if (!count_full) begin
                fetch_count_d = fetch_count_q + COUNT_W'(1);
            end
        end
    end

    // State registers; reset drops everything in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_inst_q     <= BUBBLE_INST;
            ifid_pc_plus4_q <= 32'h0000_0000;
            ifid_valid_q    <= 1'b0;
            addr_err_q      <= 1'b0;
            fetch_count_q   <= '0;
        end else begin
            pc_q            <= pc_d;
            ifid_inst_q     <= ifid_inst_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_valid_q    <= ifid_valid_d;
            addr_err_q      <= addr_err_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_inst     = ifid_inst_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_valid    = ifid_valid_q;
    assign addr_err      = addr_err_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_stage_fetch
//
// Directed bench for if_stage_fetch. A behavioural model of the fetch stage
// runs alongside the DUT and every output is compared against it on each
// falling clock edge; directed literal checks pin the model to known values.
// ----------------------------------------------------------------------------
module tb_if_stage_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        addr_err;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    if_stage_fetch #(
        .RESET_PC (32'h0000_0064),
        .COUNT_W  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_inst     (ifid_inst),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .addr_err      (addr_err),
        .fetch_count   (fetch_count)
    );

    // Clock: rising edges at 5, 15, 25 ...; falling edges are used for
    // driving stimulus and sampling outputs.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: words 25..29 hold known instructions, any
    // other address returns a scrambled word derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0064: mem_word = 32'h0022_1820;
            32'h0000_0068: mem_word = 32'h0123_2022;
            32'h0000_006C: mem_word = 32'h0085_1024;
            32'h0000_0070: mem_word = 32'h8C43_0004;
            32'h0000_0074: mem_word = 32'hAC43_0008;
            default:       mem_word = (a * 32'h9E37_79B1) + 32'h1357_9BDF;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h",
                     name, $time, actual, expected);
        end
    endtask

    // Behavioural model: what IF/ID must contain, stepped once per clock.
    logic [31:0] m_pc    = 32'h64;
    logic [31:0] m_inst  = 32'h0;
    logic [31:0] m_pc4   = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    int          m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h64; m_inst = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_err = 1'b0; m_count = 0;
        end else begin
            logic [31:0] target;
            logic        deliver;
            logic        bubble;
            target  = branch_taken ? branch_target : jump_target;
            deliver = 1'b0;
            bubble  = 1'b1;
            if (m_err) begin
                // frozen
            end else if (branch_taken || jump) begin
                if (target % 4 != 0) m_err = 1'b1;
                else                 m_pc  = target;
            end else if (stall) begin
                bubble = 1'b0;
            end else begin
                deliver = !flush;
                bubble  = flush;
                if (deliver) begin
                    m_inst = mem_word(m_pc);
                    m_pc4  = m_pc + 4;
                end
                m_pc = m_pc + 4;
            end
            if (deliver) begin
                m_valid = 1'b1;
                if (m_count < 65535) m_count = m_count + 1;
            end else if (bubble) begin
                m_valid = 1'b0;
                m_inst  = 32'h0;
            end
        end
    end

    // Every falling edge: all DUT outputs against the model.
    always @(negedge clk) begin
        checkOutput("imem_addr",     imem_addr,          m_pc);
        checkOutput("ifid_inst",     ifid_inst,          m_inst);
        checkOutput("ifid_pc_plus4", ifid_pc_plus4,      m_pc4);
        checkOutput("ifid_valid",    32'(ifid_valid),    32'(m_valid));
        checkOutput("addr_err",      32'(addr_err),      32'(m_err));
        checkOutput("fetch_count",   32'(fetch_count),   32'(m_count));
    end

    // Drive one cycle of inputs at a falling edge, let one rising edge pass,
    // then return the inputs to idle at the next falling edge.
    task automatic applyStimulus(input logic st, input logic fl,
                                 input logic bt, input logic [31:0] btgt,
                                 input logic j,  input logic [31:0] jtgt);
        stall = st; flush = fl;
        branch_taken = bt; branch_target = btgt;
        jump = j; jump_target = jtgt;
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;
    endtask

    task automatic runFree(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // Mid-cycle reset: outputs must return to reset values without a clock.
    task automatic doReset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pc",    imem_addr,        32'h64);
        checkOutput("async_rst_valid", 32'(ifid_valid),  32'h0);
        checkOutput("async_rst_err",   32'(addr_err),    32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_inst",  ifid_inst,         32'h0);
        checkOutput("rst_pc4",   ifid_pc_plus4,     32'h0);
        checkOutput("rst_count", 32'(fetch_count),  32'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_pc",    imem_addr,        32'h64);
        checkOutput("reset_valid", 32'(ifid_valid),  32'h0);

        // Free-running fetch of words 25..29
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("fr1_inst", ifid_inst,     32'h0022_1820);
        checkOutput("fr1_pc4",  ifid_pc_plus4, 32'h68);
        checkOutput("fr1_addr", imem_addr,     32'h68);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("fr2_inst", ifid_inst,     32'h0123_2022);
        checkOutput("fr2_pc4",  ifid_pc_plus4, 32'h6C);
        runFree(3);
        checkOutput("fr5_inst",  ifid_inst,        32'hAC43_0008);
        checkOutput("fr5_count", 32'(fetch_count), 32'd5);
        checkOutput("fr5_addr",  imem_addr,        32'h78);

        // Stall two cycles at pc=0x6C
        doReset();
        runFree(2);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("stall_addr",  imem_addr,        32'h6C);
        checkOutput("stall_inst",  ifid_inst,        32'h0123_2022);
        checkOutput("stall_valid", 32'(ifid_valid),  32'h1);
        checkOutput("stall_count", 32'(fetch_count), 32'd2);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("resume_addr", imem_addr, 32'h70);
        checkOutput("resume_inst", ifid_inst, 32'h0085_1024);

        // Branch + jump together under stall: branch target wins
        applyStimulus(1, 0, 1, 32'h80, 1, 32'h90);
        checkOutput("redir_addr",  imem_addr,       32'h80);
        checkOutput("redir_valid", 32'(ifid_valid), 32'h0);
        checkOutput("redir_inst",  ifid_inst,       32'h0);
        checkOutput("redir_pc4",   ifid_pc_plus4,   32'h70);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("post_redir_pc4",  ifid_pc_plus4, 32'h84);
        checkOutput("post_redir_addr", imem_addr,     32'h84);

        // Flush alone at pc=0x68
        doReset();
        runFree(1);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
        checkOutput("flush_addr",  imem_addr,        32'h6C);
        checkOutput("flush_valid", 32'(ifid_valid),  32'h0);
        checkOutput("flush_count", 32'(fetch_count), 32'd1);

        // Misaligned jump freezes fetch until reset
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h72);
        checkOutput("misal_err",  32'(addr_err), 32'h1);
        checkOutput("misal_addr", imem_addr,     32'h6C);
        runFree(10);
        checkOutput("frozen_addr",  imem_addr,       32'h6C);
        checkOutput("frozen_valid", 32'(ifid_valid), 32'h0);
        checkOutput("frozen_err",   32'(addr_err),   32'h1);
        doReset();
        checkOutput("unfreeze_addr", imem_addr,     32'h64);
        checkOutput("unfreeze_err",  32'(addr_err), 32'h0);

        // PC wrap at the top of the address space
        applyStimulus(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        checkOutput("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("wrap_addr", imem_addr,       32'h0);
        checkOutput("wrap_pc4",  ifid_pc_plus4,   32'h0);
        checkOutput("wrap_valid", 32'(ifid_valid), 32'h1);

        // Counter saturation
        doReset();
        runFree(65535);
        checkOutput("sat_full", 32'(fetch_count), 32'hFFFF);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("sat_hold",  32'(fetch_count), 32'hFFFF);
        checkOutput("sat_valid", 32'(ifid_valid),  32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
